// File: rtl/bus_responder_mem.sv
// -----------------------------------------------------------------------------
// bus_responder_mem
//
// Memory-backed target end of the DMA bus. Accepts one read or write request at
// a time, waits a programmable grant latency, then streams 64-bit read beats out
// of, or absorbs 64-bit write beats into, an internal word-addressed RAM.
//
// Parameters:
//   DEPTH_WORDS    RAM depth in 32-bit words (power of two, >= 16)
//   GRANT_LATENCY  idle cycles between request acceptance and grant (0..15)
//
// Ports:
//   clk_i          clock
//   reset_n_i      synchronous active-low reset
//   read_i         read request (level, sampled in IDLE; wins over write_i)
//   write_i        write request (level, sampled in IDLE)
//   size_i         size code, bytes = 2^size_i, legal codes 2..5
//   addr_i         byte address of the transfer
//   write_valid_i  write beat present on write_data_i (honoured in WR only)
//   write_data_i   write beat, [31:0] = lower-address word
//   grant_o        one-cycle grant pulse
//   read_valid_o   read beat valid
//   read_data_o    read beat, [31:0] = lower-address word; 0 when not valid
//   error_o        one-cycle pulse on a rejected request
//   busy_o         high in every state except IDLE
// -----------------------------------------------------------------------------
module bus_responder_mem #(
  parameter int unsigned DEPTH_WORDS   = 1024,
  parameter int unsigned GRANT_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [7:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic        write_valid_i,
  input  logic [63:0] write_data_i,
  output logic        grant_o,
  output logic        read_valid_o,
  output logic [63:0] read_data_o,
  output logic        error_o,
  output logic        busy_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GRANT,
    S_RD,
    S_WR,
    S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic            is_write_q, is_write_d;
  logic            low_only_q, low_only_d;   // 4 B transfer: high word unused
  logic [AW-1:0]   idx_q, idx_d;             // word index of current beat
  logic [2:0]      beats_q, beats_d;         // beats remaining
  logic [3:0]      wait_q, wait_d;
  logic            busy_q;

  logic [31:0]     mem_q [DEPTH_WORDS];
  logic            mem_we;

  logic [AW-1:0]   idx_hi;
  logic            size_ok;
  logic            align_ok;
  logic [2:0]      req_beats;

  // Index arithmetic is AW bits wide, so wrap modulo DEPTH_WORDS comes for free.
  assign idx_hi = idx_q + AW'(1);

  assign size_ok  = (size_i >= 8'd2) && (size_i <= 8'd5);
  // 4 B transfers need word alignment; everything larger needs 8 B alignment.
  assign align_ok = (size_i == 8'd2) ? (addr_i[1:0] == 2'b00)
                                     : (addr_i[2:0] == 3'b000);

  always_comb begin
    case (size_i)
      8'd4:    req_beats = 3'd2;
      8'd5:    req_beats = 3'd4;
      default: req_beats = 3'd1;
    endcase
  end

  // Upper address bits beyond the RAM are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^addr_i[31:AW+2];

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    is_write_d   = is_write_q;
    low_only_d   = low_only_q;
    idx_d        = idx_q;
    beats_d      = beats_q;
    wait_d       = wait_q;
    mem_we       = 1'b0;
    grant_o      = 1'b0;
    read_valid_o = 1'b0;
    read_data_o  = '0;
    error_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (read_i || write_i) begin
          is_write_d = !read_i;
          low_only_d = (size_i == 8'd2);
          idx_d      = addr_i[AW+1:2];
          beats_d    = req_beats;
          if (!(size_ok && align_ok)) begin
            state_d = S_ERR;
          end else begin
            wait_d  = 4'(GRANT_LATENCY);
            state_d = (GRANT_LATENCY == 0) ? S_GRANT : S_WAIT;
          end
        end
      end

      S_WAIT: begin
        wait_d = wait_q - 4'd1;
        if (wait_q <= 4'd1) state_d = S_GRANT;
      end

      S_GRANT: begin
        grant_o = 1'b1;
        state_d = is_write_q ? S_WR : S_RD;
      end

      S_RD: begin
        read_valid_o = 1'b1;
        read_data_o  = {(low_only_q ? 32'h0 : mem_q[idx_hi]), mem_q[idx_q]};
        idx_d        = idx_q + AW'(2);
        beats_d      = beats_q - 3'd1;
        if (beats_q == 3'd1) state_d = S_IDLE;
      end

      S_WR: begin
        if (write_valid_i) begin
          mem_we  = 1'b1;
          idx_d   = idx_q + AW'(2);
          beats_d = beats_q - 3'd1;
          if (beats_q == 3'd1) state_d = S_IDLE;
        end
      end

      S_ERR: begin
        error_o = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      is_write_q <= 1'b0;
      low_only_q <= 1'b0;
      idx_q      <= '0;
      beats_q    <= '0;
      wait_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      low_only_q <= low_only_d;
      idx_q      <= idx_d;
      beats_q    <= beats_d;
      wait_q     <= wait_d;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign busy_o = busy_q;

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------
  // NOTE: the RAM has no reset; contents survive reset and only the control
  // path is cleared. Writes are blocked while reset is asserted so an
  // abandoned beat cannot land.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && mem_we) begin
      mem_q[idx_q] <= write_data_i[31:0];
      if (!low_only_q) mem_q[idx_hi] <= write_data_i[63:32];
    end
  end

endmodule

// File: tb/tb_bus_responder_mem.sv
// -----------------------------------------------------------------------------
// tb_bus_responder_mem
//
// Directed bench for bus_responder_mem (DEPTH_WORDS = 1024, GRANT_LATENCY = 2).
// Inputs change 1 ns after the rising edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_bus_responder_mem;

  logic        clk;
  logic        reset_n;
  logic        read_r;
  logic        write_r;
  logic [7:0]  size;
  logic [31:0] addr;
  logic        write_valid;
  logic [63:0] write_data;
  logic        grant;
  logic        read_valid;
  logic [63:0] read_data;
  logic        error;
  logic        busy;

  int total = 0;
  int bad   = 0;

  bus_responder_mem #(
    .DEPTH_WORDS  (1024),
    .GRANT_LATENCY(2)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .read_i       (read_r),
    .write_i      (write_r),
    .size_i       (size),
    .addr_i       (addr),
    .write_valid_i(write_valid),
    .write_data_i (write_data),
    .grant_o      (grant),
    .read_valid_o (read_valid),
    .read_data_o  (read_data),
    .error_o      (error),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until grant_o is seen (bounded) and checks it arrived 3 cycles after
  // the request cycle. Leaves the bench in the GRANT cycle.
  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (grant !== 1'b1 && n < 20);
    check(tag, n, 3);
  endtask

  task automatic read_txn(input string tag, input logic [7:0] sz, input logic [31:0] a,
                          input int nb, input logic [63:0] e0, input logic [63:0] e1,
                          input logic [63:0] e2, input logic [63:0] e3);
    logic [63:0] exp_beats [4];
    exp_beats = '{e0, e1, e2, e3};
    read_r = 1'b1; size = sz; addr = a;
    wait_grant({tag, "_grant"});
    read_r = 1'b0;
    tick();
    for (int i = 0; i < nb; i++) begin
      check($sformatf("%s_valid%0d", tag, i), read_valid, 1'b1);
      check($sformatf("%s_data%0d", tag, i), read_data, exp_beats[i]);
      tick();
    end
    check({tag, "_valid_end"}, read_valid, 1'b0);
    check({tag, "_data_end"}, read_data, 64'h0);
    check({tag, "_busy_end"}, busy, 1'b0);
  endtask

  task automatic write_txn(input string tag, input logic [7:0] sz, input logic [31:0] a,
                           input int nb, input logic [63:0] d0, input logic [63:0] d1,
                           input logic [63:0] d2, input logic [63:0] d3);
    logic [63:0] beats [4];
    beats = '{d0, d1, d2, d3};
    write_r = 1'b1; size = sz; addr = a;
    wait_grant({tag, "_grant"});
    write_r = 1'b0;
    // A beat offered during GRANT must be ignored.
    write_valid = 1'b1; write_data = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    for (int i = 0; i < nb; i++) begin
      write_data = beats[i];
      tick();
    end
    write_valid = 1'b0;
    check({tag, "_busy_end"}, busy, 1'b0);
  endtask

  logic [63:0] w0, w1, w2, w3;
  logic [63:0] p0, p1, p2, p3;
  logic [63:0] q0, q1, q2, q3;
  logic        grant_seen;
  logic [5:0]  gap_pattern;
  int          k;

  initial begin
    reset_n = 1'b0; read_r = 1'b0; write_r = 1'b0; size = 8'd0; addr = 32'h0;
    write_valid = 1'b0; write_data = 64'h0;
    tick(); tick();
    check("rst_grant", grant, 1'b0);
    check("rst_rvalid", read_valid, 1'b0);
    check("rst_rdata", read_data, 64'h0);
    check("rst_error", error, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    tick();

    // 16 B write then read back at 0x100.
    write_txn("wr16", 8'd4, 32'h100, 2, 64'h22222222_11111111, 64'h44444444_33333333,
              64'h0, 64'h0);
    read_txn("rd16", 8'd4, 32'h100, 2, 64'h22222222_11111111, 64'h44444444_33333333,
             64'h0, 64'h0);

    // 4 B read of the odd word: high half reads as zero.
    read_txn("rd4", 8'd2, 32'h104, 1, 64'h00000000_22222222, 64'h0, 64'h0, 64'h0);

    // Simultaneous read and write: read first, write after re-sampling.
    read_r = 1'b1; write_r = 1'b1; size = 8'd3; addr = 32'h100;
    wait_grant("both_rd_grant");
    tick();
    check("both_rd_valid", read_valid, 1'b1);
    check("both_rd_data", read_data, 64'h22222222_11111111);
    read_r = 1'b0;
    tick();
    check("both_idle_busy", busy, 1'b0);
    check("both_idle_rvalid", read_valid, 1'b0);
    wait_grant("both_wr_grant");
    write_r = 1'b0;
    tick();
    write_valid = 1'b1; write_data = 64'hAAAAAAAA_BBBBBBBB;
    tick();
    write_valid = 1'b0;
    check("both_wr_busy", busy, 1'b0);
    read_txn("raw8", 8'd3, 32'h100, 1, 64'hAAAAAAAA_BBBBBBBB, 64'h0, 64'h0, 64'h0);

    // 32 B write at word 1022 with gapped valid; wraps to words 0..5.
    w0 = 64'hA0A0A0A1_A0A0A0A0; w1 = 64'hB1B1B1B1_B0B0B0B0;
    w2 = 64'hC1C1C1C1_C0C0C0C0; w3 = 64'hD1D1D1D1_D0D0D0D0;
    write_r = 1'b1; size = 8'd5; addr = 32'hFF8;
    wait_grant("wrap_grant");
    write_r = 1'b0;
    tick();
    gap_pattern = 6'b110101;   // bit i = valid in step i: 1,0,1,0,1,1
    k = 0;
    for (int i = 0; i < 6; i++) begin
      write_valid = gap_pattern[i];
      case (k)
        0: write_data = w0;
        1: write_data = w1;
        2: write_data = w2;
        default: write_data = w3;
      endcase
      if (gap_pattern[i]) k++;
      tick();
      if (i == 4) check("wrap_busy_mid", busy, 1'b1);
    end
    write_valid = 1'b0;
    check("wrap_busy_end", busy, 1'b0);
    read_txn("wrap_rd", 8'd5, 32'hFF8, 4, w0, w1, w2, w3);
    read_txn("wrap_w0", 8'd3, 32'h0, 1, w1, 64'h0, 64'h0, 64'h0);
    read_txn("wrap_w5", 8'd2, 32'h14, 1, {32'h0, w3[63:32]}, 64'h0, 64'h0, 64'h0);

    // Illegal size code.
    read_r = 1'b1; size = 8'd9; addr = 32'h0;
    tick();
    read_r = 1'b0;
    check("ill9_error", error, 1'b1);
    check("ill9_busy", busy, 1'b1);
    check("ill9_grant", grant, 1'b0);
    tick();
    check("ill9_error_end", error, 1'b0);
    check("ill9_busy_end", busy, 1'b0);

    // Misaligned 32 B write, with a beat offered that must not land.
    write_r = 1'b1; size = 8'd5; addr = 32'h4;
    write_valid = 1'b1; write_data = 64'hBAD0BAD0_BAD0BAD0;
    tick();
    write_r = 1'b0;
    check("ill5_error", error, 1'b1);
    check("ill5_busy", busy, 1'b1);
    check("ill5_grant", grant, 1'b0);
    tick();
    write_valid = 1'b0;
    check("ill5_error_end", error, 1'b0);
    check("ill5_busy_end", busy, 1'b0);
    read_txn("ill_ram01", 8'd3, 32'h0, 1, w1, 64'h0, 64'h0, 64'h0);
    read_txn("ill_ram23", 8'd3, 32'h8, 1, w2, 64'h0, 64'h0, 64'h0);

    // Reset during WAIT.
    read_r = 1'b1; size = 8'd4; addr = 32'h100;
    tick();
    check("rstw_busy_wait", busy, 1'b1);
    reset_n = 1'b0; read_r = 1'b0;
    tick();
    check("rstw_busy", busy, 1'b0);
    check("rstw_grant", grant, 1'b0);
    check("rstw_rvalid", read_valid, 1'b0);
    check("rstw_rdata", read_data, 64'h0);
    reset_n = 1'b1;
    grant_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      grant_seen = grant_seen | grant;
    end
    check("rstw_no_grant", grant_seen, 1'b0);

    // Reset after beat 2 of a 4-beat write: beats 3-4 keep old contents.
    p0 = 64'h10000001_10000000; p1 = 64'h20000001_20000000;
    p2 = 64'h30000001_30000000; p3 = 64'h40000001_40000000;
    q0 = 64'h51515151_50505050; q1 = 64'h61616161_60606060;
    q2 = 64'h71717171_70707070; q3 = 64'h81818181_80808080;
    write_txn("pre32", 8'd5, 32'h200, 4, p0, p1, p2, p3);
    write_r = 1'b1; size = 8'd5; addr = 32'h200;
    wait_grant("rstwr_grant");
    write_r = 1'b0;
    tick();
    write_valid = 1'b1; write_data = q0;
    tick();
    write_data = q1;
    tick();
    check("rstwr_busy_mid", busy, 1'b1);
    reset_n = 1'b0; write_data = q2;
    tick();
    check("rstwr_busy", busy, 1'b0);
    check("rstwr_grant", grant, 1'b0);
    check("rstwr_rvalid", read_valid, 1'b0);
    check("rstwr_error", error, 1'b0);
    reset_n = 1'b1; write_valid = 1'b0; write_data = q3;
    tick();
    read_txn("rstwr_rd", 8'd5, 32'h200, 4, q0, q1, p2, p3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
